// File: rtl/pulse_train_gen.sv
// pulse_train_gen: turns single-cycle start strobes into fixed-length high
// runs on a serial line, each separated by a guaranteed low gap. Requests that
// arrive while a run or gap is in progress wait in a saturating counter.
module pulse_train_gen #(
  parameter int HIGH_CYCLES = 3,
  parameter int GAP_CYCLES  = 1,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              dropped
);

  localparam int CNT_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO     = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE      = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX      = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_GAP  = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PEND_W-1:0]   r_pend;
  logic                r_level;
  logic                r_busy;
  logic                r_drop;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [PEND_W-1:0]   w_pend_nxt;
  logic                w_drop_nxt;
  logic                w_busy_nxt;
  logic                w_launch;
  logic                w_queue_start;
  logic                w_has_pend;
  logic                w_full;
  logic                w_cnt_zero;

  assign w_has_pend = (r_pend != PEND_ZERO);
  assign w_full     = (r_pend == PEND_MAX);
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  // Next-state, counter and queue bookkeeping; abort overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_drop_nxt    = 1'b0;
    w_launch      = 1'b0;
    w_queue_start = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = CNT_ZERO;
      w_pend_nxt  = PEND_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start || w_has_pend) begin
            w_launch = 1'b1;
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end
        ST_HIGH: begin
          w_queue_start = start;
          if (w_cnt_zero) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_GAP_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (w_cnt_zero && (start || w_has_pend)) begin
            w_launch = 1'b1;
          end else if (w_cnt_zero) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_cnt_nxt     = r_cnt - CNT_ONE;
            w_queue_start = start;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          w_pend_nxt  = PEND_ZERO;
        end
      endcase

      // A launch takes the queue head if there is one (a coincident start
      // then refills that slot); otherwise the start itself is the request.
      if (w_launch) begin
        w_state_nxt = ST_HIGH;
        w_cnt_nxt   = CNT_HIGH_LOAD;
        if (w_has_pend) begin
          w_pend_nxt = r_pend - PEND_ONE + PEND_W'(start);
        end else begin
          w_pend_nxt = PEND_ZERO;
        end
      end else if (w_queue_start) begin
        if (w_full) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend + PEND_ONE;
        end
      end else begin
        w_drop_nxt = 1'b0;
      end
    end
  end

  // busy falls as soon as the line enters its final low cycle with nothing
  // queued: from there it can only go idle unless a brand-new start arrives.
  always_comb begin
    w_busy_nxt = 1'b0;
    if (w_pend_nxt != PEND_ZERO) begin
      w_busy_nxt = 1'b1;
    end else if (w_state_nxt == ST_HIGH) begin
      w_busy_nxt = 1'b1;
    end else if ((w_state_nxt == ST_GAP) && (w_cnt_nxt != CNT_ZERO)) begin
      w_busy_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
    end
  end

  // State, counter, queue and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_pend  <= PEND_ZERO;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_level <= (w_state_nxt == ST_HIGH);
      r_busy  <= w_busy_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign level_out = r_level;
  assign busy      = r_busy;
  assign pending   = r_pend;
  assign dropped   = r_drop;

endmodule
